// File: rtl/sbox_arb_pkg.sv
// Shared types and helpers for sbox_arbiter: FSM/requester encodings, beat math, AES forward S-box.
package sbox_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_KEY   = 2'd1,
        S_STATE = 2'd2
    } state_e;

    typedef enum logic {
        REQ_KEY = 1'b0,
        REQ_ST  = 1'b1
    } req_id_e;

    // Wide enough for the 16-beat state op at LANES=1
    localparam int CNT_W = 4;

    function automatic int key_beats(input int lanes);
        return 4 / lanes;
    endfunction

    function automatic int st_beats(input int lanes);
        return 16 / lanes;
    endfunction

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

endpackage

// File: rtl/sbox_lane_bank.sv
// Purely combinational bank of LANES AES forward S-boxes, one byte per lane.
module sbox_lane_bank
    import sbox_arb_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic [8*LANES-1:0] i_bytes,
    output logic [8*LANES-1:0] o_bytes
);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign o_bytes[8*l +: 8] = sbox(i_bytes[8*l +: 8]);
    end

endmodule

// File: rtl/sbox_arbiter.sv
// Arbitrates key SubWord and state SubBytes requests onto a shared S-box lane bank, LANES bytes per beat.
// Optional SBOX_ARB_PERF_EN adds saturating op/contention counters.
module sbox_arbiter
    import sbox_arb_pkg::*;
#(
    parameter int LANES        = 4,
    parameter int KEY_PRIORITY = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_req,
    input  logic [31:0]  key_word,
    output logic         key_gnt,
    output logic         key_done,
    output logic [31:0]  key_result,
    input  logic         st_req,
    input  logic [127:0] st_data,
    output logic         st_gnt,
    output logic         st_done,
    output logic [127:0] st_result,
    output logic         busy
`ifdef SBOX_ARB_PERF_EN
    ,
    output logic [15:0]  key_ops,
    output logic [15:0]  st_ops,
    output logic [15:0]  contend_cycles
`endif
);

    localparam int LW = 8 * LANES;
    localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(key_beats(LANES) - 1);
    localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(st_beats(LANES) - 1);

    state_e         r_state;
    req_id_e        r_rr;
    logic [CNT_W-1:0] r_cnt;
    logic [127:0]   r_work;
    logic           r_key_done, r_st_done, r_busy;
    logic [31:0]    r_key_result;
    logic [127:0]   r_st_result;

    logic           w_idle, w_key_win, w_key_gnt, w_st_gnt, w_last;
    logic [6:0]     w_msb;
    logic [LW-1:0]  w_lane_in, w_lane_out;
    logic [127:0]   w_work_next;

    assign w_idle    = (r_state == S_IDLE);
    assign w_key_win = !st_req || (KEY_PRIORITY != 0) || (r_rr == REQ_KEY);
    assign w_key_gnt = w_idle && key_req && w_key_win;
    assign w_st_gnt  = w_idle && st_req && !w_key_gnt;

    // Key operands sit in the top word of the working register so both paths share byte indexing
    assign w_msb     = 7'(127 - LW * int'(r_cnt));
    assign w_lane_in = r_work[w_msb -: LW];
    assign w_last    = (r_state == S_KEY) ? (r_cnt == KEY_LAST) : (r_cnt == ST_LAST);

    sbox_lane_bank #(.LANES(LANES)) u_bank (
        .i_bytes(w_lane_in),
        .o_bytes(w_lane_out)
    );

    always_comb begin
        w_work_next = r_work;
        w_work_next[w_msb -: LW] = w_lane_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rr         <= REQ_KEY;
            r_cnt        <= '0;
            r_work       <= '0;
            r_key_done   <= 1'b0;
            r_st_done    <= 1'b0;
            r_busy       <= 1'b0;
            r_key_result <= '0;
            r_st_result  <= '0;
        end else begin
            r_key_done <= 1'b0;
            r_st_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_key_gnt) begin
                        r_work  <= {key_word, 96'b0};
                        r_state <= S_KEY;
                        r_rr    <= REQ_ST;
                        r_busy  <= 1'b1;
                    end else if (w_st_gnt) begin
                        r_work  <= st_data;
                        r_state <= S_STATE;
                        r_rr    <= REQ_KEY;
                        r_busy  <= 1'b1;
                    end
                end
                S_KEY, S_STATE: begin
                    r_work <= w_work_next;
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (r_state == S_KEY) begin
                            r_key_result <= w_work_next[127:96];
                            r_key_done   <= 1'b1;
                        end else begin
                            r_st_result <= w_work_next;
                            r_st_done   <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign key_gnt    = w_key_gnt;
    assign st_gnt     = w_st_gnt;
    assign key_done   = r_key_done;
    assign st_done    = r_st_done;
    assign key_result = r_key_result;
    assign st_result  = r_st_result;
    assign busy       = r_busy;

`ifdef SBOX_ARB_PERF_EN
    logic [15:0] r_key_ops, r_st_ops, r_contend;
    logic        w_contend;

    assign w_contend = (key_req && !w_key_gnt) || (st_req && !w_st_gnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_ops <= '0;
            r_st_ops  <= '0;
            r_contend <= '0;
        end else begin
            if (r_key_done && r_key_ops != 16'hffff) r_key_ops <= r_key_ops + 1'b1;
            if (r_st_done  && r_st_ops  != 16'hffff) r_st_ops  <= r_st_ops + 1'b1;
            if (w_contend  && r_contend != 16'hffff) r_contend <= r_contend + 1'b1;
        end
    end

    assign key_ops        = r_key_ops;
    assign st_ops         = r_st_ops;
    assign contend_cycles = r_contend;
`endif

endmodule

// File: tb/tb_sbox_arbiter.sv
// Drives four sbox_arbiter configurations (LANES 4/2/1 round-robin, LANES 4 key-priority) from shared stimulus
// and checks each against a cycle-count behavioural model with a GF(2^8)-derived S-box.
module tb_sbox_arbiter;

    localparam int NC = 4;

    logic         clk = 1'b0;
    logic         rst, key_req, st_req;
    logic [31:0]  key_word;
    logic [127:0] st_data;
    logic [NC-1:0]         kgnt, kdone, sgnt, sdone, bsy;
    logic [NC-1:0][31:0]   kres;
    logic [NC-1:0][127:0]  sres;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NC; g++) begin : g_cfg
        sbox_arbiter #(
            .LANES((g == 0 || g == 3) ? 4 : (g == 1 ? 2 : 1)),
            .KEY_PRIORITY(g == 3 ? 1 : 0)
        ) u_dut (
            .clk(clk), .rst(rst),
            .key_req(key_req), .key_word(key_word), .key_gnt(kgnt[g]),
            .key_done(kdone[g]), .key_result(kres[g]),
            .st_req(st_req), .st_data(st_data), .st_gnt(sgnt[g]),
            .st_done(sdone[g]), .st_result(sres[g]),
            .busy(bsy[g])
        );
    end

    int npass = 0, ntot = 0, cyc = 0;
    logic [7:0] msb [256];

    // model state, per configuration
    bit           m_valid = 0;
    bit           m_idle [NC];
    int           m_left [NC];
    bit           m_path [NC];
    bit           m_ptrkey [NC];
    logic [127:0] m_opnd [NC];
    logic [31:0]  m_kres [NC];
    logic [127:0] m_sres [NC];
    bit           m_kd [NC], m_sd [NC], e_kg [NC], e_sg [NC];

    // observations
    int kg_cyc [NC], kd_cyc [NC], sg_cyc [NC], sd_cyc [NC], sd_cnt [NC], sg_cnt [NC];
    bit glog0 [$];
    bit glog3 [$];

    function automatic int lnf(input int g);
        return (g == 0 || g == 3) ? 4 : (g == 1 ? 2 : 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv, s;
        inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [127:0] subst(input logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = msb[x[8*i +: 8]];
        return r;
    endfunction

    task automatic chk(input string name, input int g, input logic [127:0] act, input logic [127:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s cfg%0d got=%h exp=%h", name, g, act, exp);
    endtask

    // One clock: compare every config against the model mid-cycle, then advance the model.
    task automatic tick();
        @(negedge clk);
        for (int g = 0; g < NC; g++) begin
            e_kg[g] = m_idle[g] && key_req && (!st_req || g == 3 || m_ptrkey[g]);
            e_sg[g] = m_idle[g] && st_req && !e_kg[g];
            if (m_valid) begin
                chk("key_gnt", g, kgnt[g], e_kg[g]);
                chk("st_gnt", g, sgnt[g], e_sg[g]);
                chk("busy", g, bsy[g], !m_idle[g]);
                chk("key_done", g, kdone[g], m_kd[g]);
                chk("st_done", g, sdone[g], m_sd[g]);
                chk("key_result", g, kres[g], m_kres[g]);
                chk("st_result", g, sres[g], m_sres[g]);
            end
            if (kgnt[g] === 1'b1) begin
                kg_cyc[g] = cyc;
                if (g == 0) glog0.push_back(1'b0);
                if (g == 3) glog3.push_back(1'b0);
            end
            if (sgnt[g] === 1'b1) begin
                sg_cyc[g] = cyc;
                sg_cnt[g]++;
                if (g == 0) glog0.push_back(1'b1);
                if (g == 3) glog3.push_back(1'b1);
            end
            if (kdone[g] === 1'b1) kd_cyc[g] = cyc;
            if (sdone[g] === 1'b1) begin sd_cyc[g] = cyc; sd_cnt[g]++; end
        end
        for (int g = 0; g < NC; g++) begin
            if (rst) begin
                m_idle[g] = 1; m_left[g] = 0; m_ptrkey[g] = 1;
                m_kres[g] = '0; m_sres[g] = '0; m_kd[g] = 0; m_sd[g] = 0;
            end else begin
                m_kd[g] = 0; m_sd[g] = 0;
                if (!m_idle[g]) begin
                    m_left[g]--;
                    if (m_left[g] == 0) begin
                        m_idle[g] = 1;
                        if (!m_path[g]) begin m_kres[g] = subst(m_opnd[g])[31:0]; m_kd[g] = 1; end
                        else begin m_sres[g] = subst(m_opnd[g]); m_sd[g] = 1; end
                    end
                end else if (e_kg[g]) begin
                    m_idle[g] = 0; m_left[g] = 4 / lnf(g); m_path[g] = 0;
                    m_opnd[g] = {96'b0, key_word}; m_ptrkey[g] = 0;
                end else if (e_sg[g]) begin
                    m_idle[g] = 0; m_left[g] = 16 / lnf(g); m_path[g] = 1;
                    m_opnd[g] = st_data; m_ptrkey[g] = 1;
                end
            end
        end
        if (rst) m_valid = 1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Single-cycle request on an idle block, then drain; check per-config latency and result.
    task automatic run_op(input bit is_key, input logic [127:0] d, input logic [127:0] exp_res);
        int lat_k [NC];
        int lat_s [NC];
        lat_k = '{2, 3, 5, 2};
        lat_s = '{5, 9, 17, 5};
        for (int g = 0; g < NC; g++) begin kg_cyc[g] = -100; kd_cyc[g] = -1; sg_cyc[g] = -100; sd_cyc[g] = -1; end
        key_req = is_key; st_req = !is_key;
        if (is_key) key_word = d[31:0]; else st_data = d;
        tick();
        key_req = 0; st_req = 0;
        repeat (20) tick();
        for (int g = 0; g < NC; g++) begin
            if (is_key) begin
                chk("key_latency", g, 128'(kd_cyc[g] - kg_cyc[g]), 128'(lat_k[g]));
                chk("key_result_lit", g, kres[g], exp_res);
            end else begin
                chk("st_latency", g, 128'(sd_cyc[g] - sg_cyc[g]), 128'(lat_s[g]));
                chk("st_result_lit", g, sres[g], exp_res);
            end
        end
    endtask

    initial begin
        int sd_before;
        bit exp_rr [4];
        exp_rr = '{1'b0, 1'b1, 1'b0, 1'b1};
        rst = 1; key_req = 0; st_req = 0; key_word = '0; st_data = '0;
        for (int g = 0; g < NC; g++) begin sd_cnt[g] = 0; sg_cnt[g] = 0; m_idle[g] = 1; end
        for (int i = 0; i < 256; i++) msb[i] = sbox_calc(8'(i));

        // pin the model S-box to known table entries
        chk("model_sbox_00", 0, msb[8'h00], 8'h63);
        chk("model_sbox_53", 0, msb[8'h53], 8'hed);
        chk("model_sbox_ff", 0, msb[8'hff], 8'h16);

        tick(); tick();
        rst = 0;
        for (int g = 0; g < NC; g++) begin
            chk("reset_busy", g, bsy[g], 1'b0);
            chk("reset_st_result", g, sres[g], 128'h0);
            chk("reset_key_result", g, kres[g], 128'h0);
        end

        run_op(1'b1, 128'h00010203, 128'h637c777b);
        run_op(1'b0, 128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816);
        run_op(1'b0, 128'h0, {16{8'h63}});

        // both requesters held from reset
        rst = 1; tick(); rst = 0;
        glog0.delete(); glog3.delete();
        sg_cnt[3] = 0;
        key_req = 1; st_req = 1; key_word = 32'hdeadbeef; st_data = 128'h0123456789abcdeffedcba9876543210;
        repeat (30) tick();
        key_req = 0; st_req = 0;
        repeat (20) tick();
        chk("rr_len", 0, 128'(glog0.size() >= 4), 128'(1));
        chk("kp_len", 3, 128'(glog3.size() >= 4), 128'(1));
        for (int i = 0; i < 4; i++) begin
            chk("rr_order", 0, glog0[i], exp_rr[i]);
            chk("kp_order", 3, glog3[i], 1'b0);
        end
        chk("kp_st_starved", 3, 128'(sg_cnt[3]), 128'(0));

        // key path alone, held continuously
        key_req = 1; key_word = 32'h52096ad5;
        repeat (12) tick();
        key_req = 0;
        repeat (20) tick();

        // reset during beat 2 of a state op
        st_req = 1; st_data = 128'hffeeddccbbaa99887766554433221100;
        tick();
        st_req = 0;
        tick(); tick();
        sd_before = sd_cnt[0];
        rst = 1; tick(); rst = 0;
        chk("abort_busy", 0, bsy[0], 1'b0);
        chk("abort_st_result", 0, sres[0], 128'h0);
        repeat (20) tick();
        chk("abort_no_done", 0, 128'(sd_cnt[0]), 128'(sd_before));

        // random traffic
        for (int i = 0; i < 250; i++) begin
            key_req  = 1'($urandom_range(0, 1));
            st_req   = 1'($urandom_range(0, 1));
            key_word = $urandom;
            st_data  = {$urandom, $urandom, $urandom, $urandom};
            rst      = ($urandom_range(0, 60) == 0);
            tick();
        end
        rst = 0; key_req = 0; st_req = 0;
        repeat (20) tick();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/sbox_arbiter.md
Name: sbox_arbiter

Overview:
Shares one bank of byte-substitution lanes between two requesters: the key-schedule SubWord path (32-bit word) and the cipher-round SubBytes path (128-bit state).
- Each lane is one combinational AES forward S-box.
- The block arbitrates between the requesters, captures the operand and sequences it through the lanes over multiple beats.
- It returns a registered result with a done pulse.
- It sits between the key-expansion/round controllers and the S-box lanes, so the design carries LANES S-boxes instead of 20.

Parameters:
- LANES, 4, number of S-box lanes (bytes substituted per beat); legal values 1, 2, 4.
- KEY_PRIORITY, 0, 0 = round-robin between requesters; 1 = fixed priority, key path always wins.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- key_req  in  1  key path requests a SubWord
- key_word  in  32  operand; sampled in grant cycle
- key_gnt  out  1  combinational; high in the cycle key request is accepted
- key_done  out  1  one-cycle pulse; key_result valid
- key_result  out  32  registered SubWord result; holds until next key op completes
- st_req  in  1  state path requests a SubBytes
- st_data  in  128  operand; sampled in grant cycle
- st_gnt  out  1  combinational accept strobe
- st_done  out  1  one-cycle pulse; st_result valid
- st_result  out  128  registered SubBytes result; holds until next state op completes
- busy  out  1  high while in any non-IDLE state

Behaviour:
- Reset (synchronous, active-high) drives all of the following; rst mid-operation aborts the op, and no done pulse is issued:
  - FSM goes to IDLE.
  - key_done/st_done go to 0.
  - key_result/st_result go to 0.
  - busy goes to 0.
  - Round-robin pointer points to the key path.
  - Beat counter goes to 0.
- FSM states: IDLE, KEY, STATE.
- Grants: issued only in IDLE, and at most one per cycle.
  - gnt = IDLE & req & won-arbitration.
  - The operand is captured at the grant edge, and the FSM moves to KEY or STATE.
- Arbitration when both requesters are high:
  - KEY_PRIORITY=1: key wins.
  - KEY_PRIORITY=0: the requester not served last wins, and the pointer updates on every grant.
  - A single requester always wins.
- Request rules:
  - A requester holds req (and stable data) until gnt.
  - Dropping req before gnt is a legal withdrawal.
  - req remaining high after gnt requests a new operation.
- Beats: each beat substitutes LANES bytes of the captured operand in place.
  - Beat b covers byte indices b*LANES .. b*LANES+LANES-1.
  - Byte 0 is the MS byte (bits [127:120] for state, [31:24] for key).
  - KEY takes 4/LANES beats; STATE takes 16/LANES beats.
  - The beat counter runs 0..N-1, then returns to 0.
- Latency: with grant in cycle T, the op occupies T+1 .. T+N.
  - The result register is updated at the end of cycle T+N.
  - done is high during T+N+1.
  - The FSM is in IDLE in T+N+1, so a new grant is possible in T+N+1 (back-to-back; done and gnt may coincide).
  - LANES=4: key done at T+2, state done at T+5.
- Result update is atomic: key_result/st_result change only at op completion. Partial bytes accumulate in an internal working register, never visible on outputs.
- No operation is dropped or reordered. Each gnt produces exactly one done on the same path unless rst intervenes.

Optional Feature:
- Macro SBOX_ARB_PERF_EN.
- When defined, the block adds:
  - outputs key_ops[15:0] and st_ops[15:0]: saturating counts of completed ops.
  - output contend_cycles[15:0]: saturating count of cycles where a req is high but not granted (either requester).
  - All three reset to 0 and saturate at 0xFFFF.
- When undefined, these ports and counters do not exist, and function is otherwise identical.

Decomposition:
- Package sbox_arb_pkg holds:
  - FSM state enum
  - KEY_BEATS = 4/LANES and ST_BEATS = 16/LANES helper functions
  - beat-counter width
  - requester-ID encoding (KEY=0, ST=1)
- Sub-module sbox_lane_bank: purely combinational, instantiates LANES S-box lanes, in[8*LANES] -> out[8*LANES].

Test Plan:
- key_word=0x00010203, single request -> key_gnt at T, key_done at T+2 (LANES=4), key_result=0x637c777b.
- st_data=0x00112233445566778899aabbccddeeff -> st_done at T+5, st_result=0x638293c31bfc33f5c4eeacea4bc12816; all-zero state -> 0x6363…63.
- key_req and st_req high together from reset, KEY_PRIORITY=0, both held -> grants alternate key, st, key, st; with KEY_PRIORITY=1 -> key granted every opportunity and st starved.
- rst asserted during beat 2 of a STATE op -> next cycle: IDLE, busy=0, st_result=0, no st_done ever issued for that op.
- Back-to-back: key_req held high continuously -> a new key_gnt in the same cycle as each key_done; key_result updates only at completion.
- Sweep LANES=1 and LANES=2 -> key done at T+5/T+3, state done at T+17/T+9, with results identical to LANES=4.
